// File: rtl/bomberman_motion_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_motion_ctrl_pkg
// Purpose  : Shared types and constants for the bomberman motion controller:
//            direction encodings (also used on the collision bus), FSM state
//            encoding, screen/sprite geometry and a button decoder helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bomberman_motion_ctrl_pkg;

    // Position width shared by every coordinate in the block.
    localparam int POS_W = 10;

    // Screen and sprite geometry (pixels).
    localparam int MAX_X = 640;
    localparam int MAX_Y = 480;
    localparam int MIN_Y = 16;   // top band is reserved for the status bar
    localparam int B_W   = 16;
    localparam int B_H   = 16;

    // Direction encoding, shared by chk_dir and facing.
    typedef enum logic [1:0] {
        DIR_L = 2'b00,
        DIR_R = 2'b01,
        DIR_U = 2'b10,
        DIR_D = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_CHECK  = 2'b10,
        S_COMMIT = 2'b11
    } state_t;

    // Result of filtering the four buttons: valid only when exactly one is held.
    typedef struct packed {
        logic valid;
        dir_t dir;
    } btn_t;

    function automatic btn_t decode_buttons(input logic l, input logic r,
                                            input logic u, input logic d);
        btn_t b;
        b.valid = 1'b1;
        b.dir   = DIR_L;
        case ({l, r, u, d})
            4'b1000: b.dir = DIR_L;
            4'b0100: b.dir = DIR_R;
            4'b0010: b.dir = DIR_U;
            4'b0001: b.dir = DIR_D;
            default: b.valid = 1'b0;   // none or several buttons: ambiguous
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomberman_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_motion_ctrl_if
// Purpose  : Collision query handshake between the motion controller (master)
//            and the collision checker (slave).
// Signals  : chk_req     - query valid, held until chk_ack or timeout
//            chk_x/chk_y - candidate top-left position under query
//            chk_dir     - candidate direction
//            chk_ack     - single-cycle checker response
//            chk_blocked - candidate collides, meaningful only with chk_ack
// Revision : 1.0 - initial release
// ============================================================================
interface bomberman_motion_ctrl_if;
    import bomberman_motion_ctrl_pkg::*;

    logic             chk_req;
    logic [POS_W-1:0] chk_x;
    logic [POS_W-1:0] chk_y;
    dir_t             chk_dir;
    logic             chk_ack;
    logic             chk_blocked;

    modport master (
        output chk_req, chk_x, chk_y, chk_dir,
        input  chk_ack, chk_blocked
    );

    modport slave (
        input  chk_req, chk_x, chk_y, chk_dir,
        output chk_ack, chk_blocked
    );

endinterface
`default_nettype wire

// File: rtl/bomberman_motion_ctrl_move_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_motion_ctrl_move_tick_gen
// Purpose  : Clearable step-pacing divider. Counts 0..MOVE_DIV-1 and flags the
//            last count; clr holds the count at zero.
// Ports    : clk   - system clock
//            reset - synchronous active-high reset
//            clr   - synchronous clear (dominates counting)
//            tick  - high while the count sits at MOVE_DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module bomberman_motion_ctrl_move_tick_gen #(
    parameter int MOVE_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W    = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;   // wrap so a refused step is retried a full period later
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/bomberman_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_motion_ctrl
// Purpose  : Sequences bomberman sprite movement. Filters the direction
//            buttons into one latched direction, paces step attempts with a
//            divider, runs one collision query per step and commits the new
//            position. Sole owner of the b_x/b_y position registers.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            L, U, R, D      - direction buttons (synchronised levels)
//            game_over       - freezes motion, forces IDLE
//            chk (master)    - collision query handshake
//            b_x, b_y        - committed sprite position
//            facing          - last latched direction
//            moving          - high in any non-IDLE state
// Revision : 1.0 - initial release
// ============================================================================
module bomberman_motion_ctrl
    import bomberman_motion_ctrl_pkg::*;
#(
    parameter int MOVE_DIV    = 100000,
    parameter int CHK_TIMEOUT = 15,
    parameter int START_X     = 0,
    parameter int START_Y     = 16,
    parameter int X_MAX       = MAX_X - B_W,
    parameter int Y_MIN       = MIN_Y,
    parameter int Y_MAX       = MAX_Y - B_H
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    L,
    input  logic                    U,
    input  logic                    R,
    input  logic                    D,
    input  logic                    game_over,
    bomberman_motion_ctrl_if.master chk,
    output logic [POS_W-1:0]        b_x,
    output logic [POS_W-1:0]        b_y,
    output logic [1:0]              facing,
    output logic                    moving
);

    localparam int               TCNT_W     = $clog2(CHK_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] c_to_last = TCNT_W'(CHK_TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] c_t_one   = TCNT_W'(1);
    localparam logic [POS_W-1:0] c_start_x  = POS_W'(START_X);
    localparam logic [POS_W-1:0] c_start_y  = POS_W'(START_Y);
    localparam logic [POS_W-1:0] c_x_max    = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] c_y_min    = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] c_y_max    = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] c_one      = POS_W'(1);

    state_t            r_state;
    dir_t              r_dir;
    dir_t              r_facing;
    dir_t              r_chk_dir;
    logic [POS_W-1:0]  r_pos_x;
    logic [POS_W-1:0]  r_pos_y;
    logic [POS_W-1:0]  r_chk_x;
    logic [POS_W-1:0]  r_chk_y;
    logic              r_chk_req;
    logic              r_moving;
    logic [TCNT_W-1:0] r_tcnt;

    btn_t              w_btn;
    logic              w_hold_ok;
    logic              w_tick;
    logic              w_tick_clr;
    logic              w_in_bounds;
    logic [POS_W-1:0]  w_cand_x;
    logic [POS_W-1:0]  w_cand_y;

    assign w_btn     = decode_buttons(L, R, U, D);
    // The hold is intact only while the latched button is the sole one pressed.
    assign w_hold_ok = w_btn.valid && (w_btn.dir == r_dir);

    // The divider only runs while waiting on an intact hold; every way out of
    // WAIT (or a break in the hold) restarts the step period from zero.
    assign w_tick_clr = (r_state != S_WAIT) || game_over || !w_hold_ok;

    bomberman_motion_ctrl_move_tick_gen #(
        .MOVE_DIV (MOVE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tick_clr),
        .tick  (w_tick)
    );

    // Candidate position: the bound is tested on the current position before
    // the +/-1, so the 10-bit subtract can never wrap.
    always_comb begin
        w_cand_x    = r_pos_x;
        w_cand_y    = r_pos_y;
        w_in_bounds = 1'b0;
        case (r_dir)
            DIR_L: if (r_pos_x > '0) begin
                w_cand_x    = r_pos_x - c_one;
                w_in_bounds = 1'b1;
            end
            DIR_R: if (r_pos_x < c_x_max) begin
                w_cand_x    = r_pos_x + c_one;
                w_in_bounds = 1'b1;
            end
            DIR_U: if (r_pos_y > c_y_min) begin
                w_cand_y    = r_pos_y - c_one;
                w_in_bounds = 1'b1;
            end
            DIR_D: if (r_pos_y < c_y_max) begin
                w_cand_y    = r_pos_y + c_one;
                w_in_bounds = 1'b1;
            end
            default: w_in_bounds = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dir     <= DIR_D;
            r_facing  <= DIR_D;
            r_chk_dir <= DIR_L;
            r_pos_x   <= c_start_x;
            r_pos_y   <= c_start_y;
            r_chk_x   <= '0;
            r_chk_y   <= '0;
            r_chk_req <= 1'b0;
            r_moving  <= 1'b0;
            r_tcnt    <= '0;
        end else if (game_over) begin
            // Freeze: drop any query in flight and discard a pending commit.
            r_state   <= S_IDLE;
            r_chk_req <= 1'b0;
            r_moving  <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    if (w_btn.valid) begin
                        r_dir    <= w_btn.dir;
                        r_facing <= w_btn.dir;
                        r_moving <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_hold_ok) begin
                        r_moving <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_tick && w_in_bounds) begin
                        r_chk_x   <= w_cand_x;
                        r_chk_y   <= w_cand_y;
                        r_chk_dir <= r_dir;
                        r_chk_req <= 1'b1;
                        r_tcnt    <= '0;
                        r_state   <= S_CHECK;
                    end
                    // tick with an out-of-range candidate: stay, divider wraps
                end
                S_CHECK: begin
                    if (chk.chk_ack) begin
                        r_chk_req <= 1'b0;
                        r_state   <= chk.chk_blocked ? S_WAIT : S_COMMIT;
                    end else if (r_tcnt == c_to_last) begin
                        // No answer in time: treat as blocked and retry later.
                        r_chk_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_tcnt <= r_tcnt + c_t_one;
                    end
                end
                S_COMMIT: begin
                    r_pos_x <= r_chk_x;
                    r_pos_y <= r_chk_y;
                    r_state <= S_WAIT;
                end
                default: begin
                    r_chk_req <= 1'b0;
                    r_moving  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign chk.chk_req = r_chk_req;
    assign chk.chk_x   = r_chk_x;
    assign chk.chk_y   = r_chk_y;
    assign chk.chk_dir = r_chk_dir;

    assign b_x    = r_pos_x;
    assign b_y    = r_pos_y;
    assign facing = r_facing;
    assign moving = r_moving;

endmodule
`default_nettype wire
